// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: FIFO bus; master drives clr/wr_en/buf_in/rd_en, slave (FIFO) drives buf_out/flags/fifo_cnt/error pulses
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] buf_in;
  logic              rd_en;
  logic [DATA_W-1:0] buf_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              overflow;
  logic              underflow;
  modport master (
    output clr, wr_en, buf_in, rd_en,
    input  buf_out, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
  );
  modport slave (
    input  clr, wr_en, buf_in, rd_en,
    output buf_out, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO (clk, async rst_n, bus slave: clr/wr_en/buf_in/rd_en in; buf_out, full/empty/almost flags, fifo_cnt, overflow/underflow out; optional FWFT read)
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_q;
  logic              ovf, unf, wr_acc, rd_acc;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign wr_acc           = bus.wr_en & ~bus.full;
  assign rd_acc           = bus.rd_en & ~bus.empty;
  assign bus.full         = cnt == CNT_W'(DEPTH);
  assign bus.empty        = cnt == '0;
  assign bus.almost_full  = cnt >= CNT_W'(AFULL_TH);
  assign bus.almost_empty = cnt <= CNT_W'(AEMPTY_TH);
  assign bus.fifo_cnt     = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
  assign bus.buf_out      = FWFT != 0 ? mem[rd_ptr] : rd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= inc(wr_ptr);
      if (rd_acc) begin
        rd_ptr <= inc(rd_ptr);
        rd_q   <= mem[rd_ptr];
      end
      cnt <= cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      ovf <= bus.wr_en & bus.full;
      unf <= bus.rd_en & bus.empty;
    end
  always_ff @(posedge clk)
    if (rst_n && !bus.clr && wr_acc) mem[wr_ptr] <= bus.buf_in;
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO, the successor to the team's fixed 8x8 FIFO.
- Generalises data width and depth and uses the full capacity: full asserts at DEPTH entries, not DEPTH-1.
- Adds almost-full/almost-empty thresholds, overflow/underflow error pulses, a synchronous clear and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in the same clock domain as a general elastic buffer.

Parameters:
- DATA_W, 8, data width in bits (>=1).
- DEPTH, 8, number of storage entries (>=2; need not be a power of 2).
- AFULL_TH, 6, almost_full asserts when fifo_cnt >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when fifo_cnt <= AEMPTY_TH (0..DEPTH-1).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- CNT_W, $clog2(DEPTH+1), width of fifo_cnt (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; highest priority after reset.
- wr_en  input  1  write request.
- buf_in  input  DATA_W  write data.
- rd_en  input  1  read request.
- buf_out  output  DATA_W  read data.
- full  output  1  fifo_cnt == DEPTH.
- empty  output  1  fifo_cnt == 0.
- almost_full  output  1  fifo_cnt >= AFULL_TH.
- almost_empty  output  1  fifo_cnt <= AEMPTY_TH.
- fifo_cnt  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, fifo_cnt are 0.
  - buf_out is 0 (FWFT=0), overflow and underflow are 0.
  - Flags: empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? 1 : 0).
  - Memory contents are not reset.
- clr=1 at a clock edge:
  - Pointers and fifo_cnt go to 0.
  - overflow and underflow go to 0.
  - wr_en and rd_en are ignored that cycle.
  - buf_out holds its value (FWFT=0).
- Acceptance:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Both are evaluated on pre-edge state.
- Simultaneous read and write:
  - Not full, not empty: both accepted, fifo_cnt unchanged, both pointers advance.
  - When full: only the read is accepted, fifo_cnt becomes DEPTH-1, overflow pulses.
  - When empty: only the write is accepted, fifo_cnt becomes 1, underflow pulses. There is no write-to-read bypass.
- Count update: fifo_cnt += wr_acc - rd_acc. The count is exact, computed from accepted operations only, never from raw enables.
- Pointer wrap: pointers are $clog2(DEPTH) bits; a pointer at DEPTH-1 goes to 0 on advance (explicit compare, valid for non-power-of-2 DEPTH).
- Write: on wr_acc, mem[wr_ptr] <= buf_in.
- Read, FWFT=0:
  - On rd_acc, buf_out <= mem[rd_ptr], visible the cycle after the rd_en edge (latency 1).
  - buf_out holds otherwise.
- Read, FWFT=1:
  - buf_out = mem[rd_ptr] combinationally whenever empty=0, so the head word is visible with rd_en low.
  - rd_acc pops the word and exposes the next one after the edge.
  - First written word is visible the cycle after its write edge.
  - buf_out is don't-care while empty.
- Status flags (full, empty, almost_full, almost_empty) are decoded from the registered fifo_cnt and change only at clock edges.
- Error pulses:
  - overflow <= wr_en & full.
  - underflow <= rd_en & empty.
  - Each is registered and high for exactly one cycle per offending request cycle.
  - No state changes on a rejected request.

Test Plan:
- Reset, then write 0x01..0x08 on consecutive cycles (DEPTH=8, FWFT=0) -> fifo_cnt 1..8; full=1 after the 8th edge; almost_full=1 from cnt=6; then read 8 cycles -> buf_out 0x01..0x08, each one cycle after its rd_en; empty=1 at end.
- Full FIFO, wr_en=1 with 0xAA for 2 cycles -> overflow high 2 cycles, fifo_cnt stays 8, a later drain returns no 0xAA.
- Empty FIFO, rd_en=1 -> underflow 1-cycle pulse, buf_out unchanged, fifo_cnt=0; with wr_en=1 also asserted same cycle -> cnt=1 and underflow still pulses.
- DEPTH=5, 12 write/read interleavings crossing wrap twice with simultaneous wr/rd at cnt=3 -> cnt stays 3, data order preserved (checked against a scoreboard).
- FWFT=1: write 0x5C to empty FIFO -> buf_out=0x5C on the next cycle with rd_en=0; rd_en pulse -> empty=1.
- Fill with 4 words, assert rst_n=0 mid-cycle -> outputs go to reset values immediately; separately, clr=1 with wr_en=1 -> cnt=0 and empty=1 next cycle, write discarded.
